// File: rtl/serial_ripple_subtractor_pkg.sv
// serial_ripple_subtractor_pkg: shared FSM state encoding and default operand width
// Contents: state_t (IDLE/SHIFT/DONE, 2-bit), DEFAULT_WIDTH.
package serial_ripple_subtractor_pkg;
   localparam int DEFAULT_WIDTH = 4;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit a - b - bin built from two half-subtractor stages and an OR
// Ports: a, b, bin (inputs); d difference bit, bout borrow out (outputs).
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   logic d1, b1, b2;
   assign d1 = a ^ b;
   assign b1 = ~a & b;
   assign d = d1 ^ bin;
   // ~d1 is ~(a^b): the second stage borrows only when the first left a zero
   assign b2 = ~d1 & bin;
   assign bout = b1 | b2;
endmodule

// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor: bit-serial a - b - bin, one bit per clock through a single full subtractor
// Ports: clk, rst (async, active-high); start, a, b, bin request/operands;
//        busy (state != IDLE), done (one-cycle result pulse), diff, bout (held results).
module serial_ripple_subtractor
   import serial_ripple_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);
   localparam int CW = $clog2(WIDTH) + 1;
   state_t state, state_n;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh;
   logic [CW-1:0] cnt;
   logic br, d, bo, accept, last;
   full_subtractor u_fs (
      .a(a_sh[0]),
      .b(b_sh[0]),
      .bin(br),
      .d(d),
      .bout(bo)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;
   always_comb begin
      accept = (state == IDLE) && start;
      last = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
      state_n = accept ? SHIFT : last ? DONE : (state == DONE) ? IDLE : state;
   end
   // busy follows the next state so it is a plain flop, aligned with the state register
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
         diff <= '0;
         bout <= 1'b0;
         a_sh <= '0;
         b_sh <= '0;
         res_sh <= '0;
         br <= 1'b0;
         cnt <= '0;
      end else begin
         busy <= state_n != IDLE;
         done <= last;
         if (accept) begin
            a_sh <= a;
            b_sh <= b;
            br <= bin;
            cnt <= '0;
         end else if (state == SHIFT) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res_sh <= {d, res_sh[WIDTH-1:1]};
            br <= bo;
            cnt <= cnt + CW'(1);
         end
         // the MSB's difference bit is still combinational here, so fold it in directly
         if (last) begin
            diff <= {d, res_sh[WIDTH-1:1]};
            bout <= bo;
         end
      end
endmodule

// File: doc/serial_ripple_subtractor.md
# serial_ripple_subtractor

Bit-serial ripple-borrow subtractor that computes `a - b - bin` one bit per clock using a single full-subtractor cell. It is the inverse-arithmetic companion to the team's registered ripple-carry adder. It trades area for latency: WIDTH cycles per operation, driven by a start/busy/done handshake. Results are registered and held until the next completion.

## Interface
- `WIDTH`, default 4, operand and difference width (≥2).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  minuend; captured on accepted start.
- `b`  in  WIDTH  subtrahend; captured on accepted start.
- `bin`  in  1  borrow-in; captured on accepted start.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; result valid.
- `diff`  out  WIDTH  registered difference, LSB-first assembled.
- `bout`  out  1  registered final borrow; 1 ⇔ a < b + bin (unsigned).

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE:**
  - `start` = 1 → capture a, b, bin into shift regs `a_sh`, `b_sh`, borrow reg `br`; `cnt` ← 0; go to SHIFT.
  - `start` = 0 → stay in IDLE.
- **SHIFT:** each cycle, the full subtractor takes `a_sh[0]`, `b_sh[0]`, `br` and produces bit `d` and borrow `bo`.
  - `a_sh`, `b_sh` shift right.
  - `d` shifts into `res_sh` from the MSB side (right shift).
  - `br` ← `bo`; `cnt` ← `cnt` + 1.
  - On the cycle processing bit WIDTH-1: `diff` ← final `res_sh` (including `d`), `bout` ← `bo`, `done` ← 1; go to DONE.
- **DONE:** `done` ← 0; go to IDLE. `start` is ignored in this state.
- Arithmetic is modulo 2^WIDTH. `diff` = (a − b − bin) mod 2^WIDTH.
- `diff`/`bout` change only at completion and hold their value otherwise.
- `start` while busy: ignored, no queuing. Input changes after capture have no effect.
- `cnt` width: clog2(WIDTH)+1. No wrap occurs within an operation.
- Reset (any time, including mid-SHIFT):
  - State → IDLE.
  - `busy` = 0, `done` = 0, `diff` = 0, `bout` = 0.
  - Internal regs cleared; the aborted operation produces no `done`.

## Timing
- Start accepted at edge E0 → `busy` high after E0.
- Bits 0..WIDTH-1 are processed at edges E1..E_WIDTH.
- `done`, `diff`, `bout` update at E_WIDTH. `done` is high for the single cycle between E_WIDTH and E_WIDTH+1.
- At E_WIDTH+1: back to IDLE, `busy` low. The earliest next accepted start is edge E_WIDTH+2.
- Throughput: one result per WIDTH+2 cycles with `start` held high.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Shared package holds:
  - State enum (IDLE/SHIFT/DONE, 2-bit).
  - Default WIDTH constant.
- Sub-module `full_subtractor`:
  - d = a^b^bin.
  - bout = (~a & b) | (~(a^b) & bin).
  - Built from two half-subtractor stages plus an OR, mirroring the adder's HA-based FA.
- The top holds the FSM, counter, operand/result shift registers and output registers.

## Test plan
- WIDTH=4, a=9, b=3, bin=0, start pulse → `done` 4 cycles after the accept edge, `diff`=6, `bout`=0, `busy` high for 5 cycles.
- a=3, b=9, bin=0 → `diff`=0xA, `bout`=1. Then a=0, b=0, bin=1 → `diff`=0xF, `bout`=1. Then a=0xF, b=0xF, bin=0 → `diff`=0, `bout`=0.
- Pulse `start` with a=5, b=1 while busy during a 9−3 operation → ignored: exactly one `done`, `diff`=6.
- Assert `rst` during the cycle processing bit 2 → `busy`, `done`, `diff`, `bout` all 0 immediately, no `done` pulse. After release, a=7, b=2 → `diff`=5, `bout`=0.
- `start` held high across two operations (12−5, then 1−2) → `done` pulses spaced 6 cycles apart; results 7/0, then 0xF/1. Outputs hold between pulses.
- Exhaustive WIDTH=4 sweep of a, b, bin vs. reference model → `{bout, diff}` equals the 5-bit result of (a − b − bin) for all 512 cases.
